i2c_mem_slave: RTL and testbench
================================

Name: i2c_mem_slave

Overview:
- I2C-style serial slave that bridges a two-wire bus (SCL/SDA) to an 8-bit synchronous memory port.
- Frame format: 8-bit device ID, R/W bit, ACK, 8-bit memory address, ACK, one data byte, ACK.
- Oversamples SCL/SDA with the fast system clock clk8x (at least 8× SCL), detects START/STOP, and issues single-cycle memory read/write strobes.
- Exposes state and shift-register contents for debug.

Parameters:
- none; all widths are fixed at 8 bits for data, address and ID.

Ports:
- clk8x  in  1  system clock; everything is synchronous to its rising edge; also clocks the attached memory
- reset  in  1  asynchronous, active-high reset
- scl  in  1  bus clock from master
- sda_in  in  1  sampled SDA line
- sda_oe  out  1  open-drain pull-low enable; 1 = drive SDA to 0, 0 = release (bus pulls high)
- id  in  8  this slave's device ID
- mem_ce  out  1  memory chip enable
- mem_rden  out  1  memory read strobe
- mem_wren  out  1  memory write strobe
- mem_addr  out  8  memory address
- mem_wdata  out  8  memory write data
- mem_rdata  in  8  memory read data, valid one clk8x cycle after rden
- slave_state  out  4  current FSM state (debug)
- slave_data  out  8  current shift/data register (debug)

Behaviour:
- Input sampling: scl and sda_in pass through 2-flop synchronizers; edges are detected from the synchronized values.
- START (including repeated start): SDA falls while SCL is high. Recognized from any state; enters DEV_ADDR with bit count 0.
- STOP: SDA rises while SCL is high. Recognized from any state; enters IDLE and releases SDA.
- Data bits are sampled on SCL rising edges, MSB first. The slave changes sda_oe only on SCL falling edges.
- States (encoding):
  - IDLE=0
  - DEV_ADDR=1: 8 bits shifted in
  - RW=2: 1 bit; 1 = read, 0 = write
  - ACK_DEV=3
  - MEM_ADDR=4: 8 bits
  - ACK_MEM=5
  - READ_DATA=6
  - WRITE_DATA=7
  - ACK_DATA=8
  - WAIT=9
- ACK_DEV:
  - If the shifted byte equals id, drive sda_oe=1 for the ACK clock.
  - Otherwise release SDA and enter IDLE; ignore the bus until the next START.
- ACK_MEM:
  - Slave drives ACK (sda_oe=1) and latches mem_addr.
  - For a read: pulse mem_ce=mem_rden=1 for exactly one clk8x cycle on the ACK rising SCL edge; capture mem_rdata into the data register on the next cycle.
- READ_DATA:
  - On each SCL falling edge, sda_oe = ~data_bit, MSB first. 8 bits.
  - After the 8th bit, release SDA and enter ACK_DATA to sample the master's ACK/NACK.
- WRITE_DATA:
  - Shift in 8 bits.
  - After the 8th rising edge, pulse mem_ce=mem_wren=1 for one clk8x cycle, with mem_addr and mem_wdata = shifted byte.
  - Then drive ACK in ACK_DATA.
- After ACK_DATA: enter WAIT with SDA released. No address auto-increment; only START or STOP leaves WAIT.
- Outside ACK and read-data bit windows, sda_oe=0.
- Reset: asserting reset mid-transfer aborts immediately and sets:
  - state=IDLE
  - sda_oe=0
  - mem_ce=mem_rden=mem_wren=0
  - mem_addr=0, mem_wdata=0
  - data register = 0, slave_data=0
  - bit counter = 0
- Strobes are never asserted together. A START during an ACK or data phase aborts with no memory write.

Test Plan:
- Reset asserted with SCL toggling → slave_state=0, sda_oe=0, all mem strobes 0.
- Memory preloaded with mem[1]=0x05; START, id=0x01, R=1, addr=0x01 → slave ACKs both bytes, one rden pulse with addr=0x01, SDA serializes 0x05 MSB first; master ACK → WAIT.
- STOP, START, id=0x01, W=0, addr=0x02, data 0x7F → ACKs, single wren pulse with addr=0x02, wdata=0x7F; slave_data=0x7F.
- Repeated START, read addr 0x02 → SDA returns 0x7F.
- Device ID 0x03 while id=0x01 → no ACK (sda_oe stays 0), no strobes, state=IDLE until next START.
- Reset pulse mid-WRITE_DATA → no wren pulse, state=IDLE, subsequent transaction works normally.

Source files
------------

// File: rtl/i2c_mem_slave.sv
// i2c_mem_slave
// Two-wire (SCL/SDA) serial slave bridging to an 8-bit synchronous memory.
// Frame: 8-bit device ID, R/W bit, ACK, 8-bit memory address, ACK,
// one data byte, ACK. SCL/SDA are oversampled by clk8x (>= 8x SCL).
//
// Ports:
//   clk8x       system clock; also clocks the attached memory
//   reset       asynchronous active-high reset
//   scl         bus clock from master
//   sda_in      sampled SDA line
//   sda_oe      1 = pull SDA low, 0 = release
//   id          this slave's device ID
//   mem_ce      memory chip enable (pulses with rden/wren)
//   mem_rden    single-cycle read strobe
//   mem_wren    single-cycle write strobe
//   mem_addr    memory address (latched during the address ACK)
//   mem_wdata   memory write data
//   mem_rdata   memory read data, valid one cycle after mem_rden
//   slave_state current FSM state (debug)
//   slave_data  current shift/data register (debug)
module i2c_mem_slave (
    input  logic       clk8x,
    input  logic       reset,
    input  logic       scl,
    input  logic       sda_in,
    output logic       sda_oe,
    input  logic [7:0] id,
    output logic       mem_ce,
    output logic       mem_rden,
    output logic       mem_wren,
    output logic [7:0] mem_addr,
    output logic [7:0] mem_wdata,
    input  logic [7:0] mem_rdata,
    output logic [3:0] slave_state,
    output logic [7:0] slave_data
);

    localparam logic [3:0] ST_IDLE       = 4'd0;
    localparam logic [3:0] ST_DEV_ADDR   = 4'd1;
    localparam logic [3:0] ST_RW         = 4'd2;
    localparam logic [3:0] ST_ACK_DEV    = 4'd3;
    localparam logic [3:0] ST_MEM_ADDR   = 4'd4;
    localparam logic [3:0] ST_ACK_MEM    = 4'd5;
    localparam logic [3:0] ST_READ_DATA  = 4'd6;
    localparam logic [3:0] ST_WRITE_DATA = 4'd7;
    localparam logic [3:0] ST_ACK_DATA   = 4'd8;
    localparam logic [3:0] ST_WAIT       = 4'd9;

    // [0],[1] form the synchronizer; [2] is the previous synchronized value
    // used for edge detection. Reset to 1 to match an idle bus.
    logic [2:0] scl_sr_reg;
    logic [2:0] sda_sr_reg;

    logic [3:0] state_reg;
    logic [3:0] bit_cnt_reg;
    logic [7:0] data_reg;
    logic       rw_reg;
    logic       rden_d_reg;

    logic sda_s;
    logic scl_rise;
    logic scl_fall;
    logic start_det;
    logic stop_det;

    assign sda_s     = sda_sr_reg[1];
    assign scl_rise  =  scl_sr_reg[1] & ~scl_sr_reg[2];
    assign scl_fall  = ~scl_sr_reg[1] &  scl_sr_reg[2];
    assign start_det =  sda_sr_reg[2] & ~sda_sr_reg[1] & scl_sr_reg[1];
    assign stop_det  = ~sda_sr_reg[2] &  sda_sr_reg[1] & scl_sr_reg[1];

    assign slave_state = state_reg;
    assign slave_data  = data_reg;

    always_ff @(posedge clk8x or posedge reset) begin
        if (reset) begin
            scl_sr_reg <= 3'b111;
            sda_sr_reg <= 3'b111;
        end else begin
            scl_sr_reg <= {scl_sr_reg[1:0], scl};
            sda_sr_reg <= {sda_sr_reg[1:0], sda_in};
        end
    end

    always_ff @(posedge clk8x or posedge reset) begin
        if (reset) begin
            state_reg   <= ST_IDLE;
            bit_cnt_reg <= 4'd0;
            data_reg    <= 8'd0;
            rw_reg      <= 1'b0;
            rden_d_reg  <= 1'b0;
            sda_oe      <= 1'b0;
            mem_ce      <= 1'b0;
            mem_rden    <= 1'b0;
            mem_wren    <= 1'b0;
            mem_addr    <= 8'd0;
            mem_wdata   <= 8'd0;
        end else begin
            // Strobes are single-cycle unless re-asserted below.
            mem_ce     <= 1'b0;
            mem_rden   <= 1'b0;
            mem_wren   <= 1'b0;
            rden_d_reg <= mem_rden;
            // Memory answers one cycle after the strobe; pick it up then.
            if (rden_d_reg)
                data_reg <= mem_rdata;

            if (start_det) begin
                state_reg   <= ST_DEV_ADDR;
                bit_cnt_reg <= 4'd0;
                sda_oe      <= 1'b0;
            end else if (stop_det) begin
                state_reg   <= ST_IDLE;
                bit_cnt_reg <= 4'd0;
                sda_oe      <= 1'b0;
            end else begin
                case (state_reg)
                    ST_DEV_ADDR, ST_MEM_ADDR, ST_WRITE_DATA: begin
                        if (scl_rise) begin
                            data_reg <= {data_reg[6:0], sda_s};
                            if (bit_cnt_reg == 4'd7) begin
                                bit_cnt_reg <= 4'd0;
                                if (state_reg == ST_DEV_ADDR) begin
                                    state_reg <= ST_RW;
                                end else if (state_reg == ST_MEM_ADDR) begin
                                    state_reg <= ST_ACK_MEM;
                                end else begin
                                    mem_wdata <= {data_reg[6:0], sda_s};
                                    mem_ce    <= 1'b1;
                                    mem_wren  <= 1'b1;
                                    state_reg <= ST_ACK_DATA;
                                end
                            end else begin
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    ST_RW: begin
                        if (scl_rise) begin
                            rw_reg    <= sda_s;
                            state_reg <= ST_ACK_DEV;
                        end
                    end
                    // In the ACK states bit_cnt_reg marks the phase:
                    // 0 = ACK clock not yet started, 1 = ACK being driven.
                    ST_ACK_DEV: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == 4'd0) begin
                                if (data_reg == id) begin
                                    sda_oe      <= 1'b1;
                                    bit_cnt_reg <= 4'd1;
                                end else begin
                                    sda_oe    <= 1'b0;
                                    state_reg <= ST_IDLE;
                                end
                            end else begin
                                sda_oe      <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= ST_MEM_ADDR;
                            end
                        end
                    end
                    ST_ACK_MEM: begin
                        if (scl_fall && bit_cnt_reg == 4'd0) begin
                            sda_oe      <= 1'b1;
                            bit_cnt_reg <= 4'd1;
                            mem_addr    <= data_reg;
                        end else if (scl_fall) begin
                            if (rw_reg) begin
                                // This fall also starts the first read bit.
                                sda_oe      <= ~data_reg[7];
                                bit_cnt_reg <= 4'd1;
                                state_reg   <= ST_READ_DATA;
                            end else begin
                                sda_oe      <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= ST_WRITE_DATA;
                            end
                        end else if (scl_rise && rw_reg) begin
                            mem_ce   <= 1'b1;
                            mem_rden <= 1'b1;
                        end
                    end
                    ST_READ_DATA: begin
                        if (scl_fall) begin
                            if (bit_cnt_reg == 4'd8) begin
                                sda_oe      <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= ST_ACK_DATA;
                            end else begin
                                // ~count selects bit 7-count (MSB first).
                                sda_oe      <= ~data_reg[~bit_cnt_reg[2:0]];
                                bit_cnt_reg <= bit_cnt_reg + 4'd1;
                            end
                        end
                    end
                    ST_ACK_DATA: begin
                        if (rw_reg) begin
                            // Master's ACK/NACK clock; either way we wait.
                            if (scl_rise)
                                state_reg <= ST_WAIT;
                        end else if (scl_fall) begin
                            if (bit_cnt_reg == 4'd0) begin
                                sda_oe      <= 1'b1;
                                bit_cnt_reg <= 4'd1;
                            end else begin
                                sda_oe      <= 1'b0;
                                bit_cnt_reg <= 4'd0;
                                state_reg   <= ST_WAIT;
                            end
                        end
                    end
                    default: begin
                        // IDLE and WAIT: only START/STOP move us on.
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_i2c_mem_slave.sv
// Testbench for i2c_mem_slave: bus-level master tasks, a memory model
// attached to the memory port, and a transaction-level reference memory.
module tb_i2c_mem_slave;

    localparam int H = 8;                  // clk8x cycles per SCL half period
    localparam logic [7:0] MY_ID = 8'h01;

    logic       clk8x = 1'b0;
    logic       reset = 1'b1;
    logic       scl   = 1'b1;
    logic       sda_m = 1'b1;
    logic       sda_in;
    logic       sda_oe;
    logic       mem_ce, mem_rden, mem_wren;
    logic [7:0] mem_addr, mem_wdata;
    logic [7:0] mem_rdata = 8'd0;
    logic [3:0] slave_state;
    logic [7:0] slave_data;

    always #5 clk8x = ~clk8x;

    // Open-drain bus: anyone pulling low wins.
    assign sda_in = sda_m & ~sda_oe;

    i2c_mem_slave dut (
        .clk8x(clk8x), .reset(reset), .scl(scl), .sda_in(sda_in),
        .sda_oe(sda_oe), .id(MY_ID), .mem_ce(mem_ce), .mem_rden(mem_rden),
        .mem_wren(mem_wren), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .slave_state(slave_state), .slave_data(slave_data)
    );

    // Attached synchronous memory and the independent reference contents.
    logic [7:0] mem     [256];
    logic [7:0] ref_mem [256];

    always @(posedge clk8x) begin
        if (mem_ce && mem_rden) mem_rdata <= mem[mem_addr];
        if (mem_ce && mem_wren) mem[mem_addr] <= mem_wdata;
    end

    // Strobe / drive monitor.
    int rden_cyc = 0, wren_cyc = 0, oe_cyc = 0, both_cyc = 0, noce_cyc = 0;
    logic [7:0] last_rd_addr = 8'd0, last_wr_addr = 8'd0, last_wr_data = 8'd0;

    always @(negedge clk8x) begin
        if (mem_rden) begin rden_cyc++; last_rd_addr = mem_addr; end
        if (mem_wren) begin wren_cyc++; last_wr_addr = mem_addr; last_wr_data = mem_wdata; end
        if (sda_oe) oe_cyc++;
        if (mem_rden && mem_wren) both_cyc++;
        if ((mem_rden || mem_wren) && !mem_ce) noce_cyc++;
    end

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk8x);
    endtask

    task automatic start_cond();
        tick(1); sda_m = 1'b1; tick(H);
        scl = 1'b1; tick(H);
        sda_m = 1'b0; tick(H);
        scl = 1'b0;
    endtask

    task automatic stop_cond();
        tick(1); sda_m = 1'b0; tick(H);
        scl = 1'b1; tick(H);
        sda_m = 1'b1; tick(H);
    endtask

    task automatic send_bit(input logic b);
        tick(1); sda_m = b; tick(H - 1);
        scl = 1'b1; tick(H);
        scl = 1'b0;
    endtask

    task automatic recv_bit(output logic b);
        tick(1); sda_m = 1'b1; tick(H - 1);
        scl = 1'b1; tick(H / 2);
        b = sda_in; tick(H / 2);
        scl = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic recv_byte(output logic [7:0] v);
        logic b;
        for (int i = 7; i >= 0; i--) begin recv_bit(b); v[i] = b; end
    endtask

    typedef struct {
        bit         rep;   // repeated START instead of STOP+START
        bit         rd;
        logic [7:0] dev;
        logic [7:0] addr;
        logic [7:0] wd;
    } vec_t;

    vec_t vecs[16];

    // One full transaction, checked against the reference memory.
    task automatic run_txn(input vec_t v, input int idx);
        int r0, w0, o0;
        logic a;
        logic [7:0] got;
        bit match;
        match = (v.dev == MY_ID);
        if (!v.rep) stop_cond();
        start_cond();
        r0 = rden_cyc; w0 = wren_cyc;
        send_byte(v.dev); send_bit(v.rd); recv_bit(a);
        chk("dev_ack", int'(a), match ? 0 : 1);
        if (!match) begin
            chk("nak_state", int'(slave_state), 0);
            o0 = oe_cyc;
            send_byte(v.addr);
            tick(H);
            chk("nak_oe_cycles", oe_cyc - o0, 0);
            chk("nak_rden", rden_cyc - r0, 0);
            chk("nak_wren", wren_cyc - w0, 0);
            chk("nak_state_end", int'(slave_state), 0);
            $display("txn %0d: dev=%02h ignored (id %02h)", idx, v.dev, MY_ID);
            return;
        end
        send_byte(v.addr); recv_bit(a);
        chk("addr_ack", int'(a), 0);
        if (v.rd) begin
            recv_byte(got);
            send_bit(1'b0);
            tick(2);
            chk("rd_data", int'(got), int'(ref_mem[v.addr]));
            chk("rden_cycles", rden_cyc - r0, 1);
            chk("rden_addr", int'(last_rd_addr), int'(v.addr));
            chk("rd_wren", wren_cyc - w0, 0);
            chk("rd_wait_state", int'(slave_state), 9);
            chk("rd_oe_released", int'(sda_oe), 0);
            $display("txn %0d: read  addr=%02h data=%02h", idx, v.addr, got);
        end else begin
            send_byte(v.wd); recv_bit(a);
            tick(H);
            chk("data_ack", int'(a), 0);
            chk("wren_cycles", wren_cyc - w0, 1);
            chk("wren_addr", int'(last_wr_addr), int'(v.addr));
            chk("wren_data", int'(last_wr_data), int'(v.wd));
            chk("wr_slave_data", int'(slave_data), int'(v.wd));
            chk("wr_rden", rden_cyc - r0, 0);
            chk("wr_wait_state", int'(slave_state), 9);
            chk("wr_oe_released", int'(sda_oe), 0);
            ref_mem[v.addr] = v.wd;
            $display("txn %0d: write addr=%02h data=%02h", idx, v.addr, v.wd);
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

    initial begin
        int w0;
        logic a;
        vec_t v;

        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'(i) ^ 8'h04;    // gives mem[1] = 0x05
            ref_mem[i] = 8'(i) ^ 8'h04;
        end

        vecs[0] = '{1'b0, 1'b1, 8'h01, 8'h01, 8'h00};
        vecs[1] = '{1'b0, 1'b0, 8'h01, 8'h02, 8'h7F};
        vecs[2] = '{1'b1, 1'b1, 8'h01, 8'h02, 8'h00};
        vecs[3] = '{1'b0, 1'b0, 8'h03, 8'h04, 8'h55};
        for (int i = 4; i < 16; i++) begin
            vecs[i].rep  = 1'($urandom_range(0, 1));
            vecs[i].rd   = 1'($urandom_range(0, 1));
            vecs[i].dev  = ($urandom_range(0, 4) == 0) ? 8'($urandom_range(2, 255)) : MY_ID;
            vecs[i].addr = 8'($urandom_range(0, 7));
            vecs[i].wd   = 8'($urandom);
        end

        // Reset held while SCL toggles.
        for (int i = 0; i < 4; i++) begin scl = ~scl; tick(H); end
        chk("rst_state", int'(slave_state), 0);
        chk("rst_oe", int'(sda_oe), 0);
        chk("rst_strobes", int'({mem_ce, mem_rden, mem_wren}), 0);
        chk("rst_slave_data", int'(slave_data), 0);
        chk("rst_mem_addr", int'(mem_addr), 0);
        scl = 1'b1; sda_m = 1'b1; tick(2);
        reset = 1'b0; tick(4);
        chk("post_rst_state", int'(slave_state), 0);
        $display("reset: state=%0d oe=%0b", slave_state, sda_oe);

        for (int i = 0; i < 16; i++) run_txn(vecs[i], i);

        // Reset in the middle of a write data byte.
        stop_cond(); start_cond();
        send_byte(MY_ID); send_bit(1'b0); recv_bit(a);
        send_byte(8'h30); recv_bit(a);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
        chk("pre_rst_state", int'(slave_state), 7);
        w0 = wren_cyc;
        reset = 1'b1; tick(3);
        chk("midrst_state", int'(slave_state), 0);
        chk("midrst_oe", int'(sda_oe), 0);
        chk("midrst_data", int'(slave_data), 0);
        chk("midrst_addr", int'(mem_addr), 0);
        chk("midrst_wdata", int'(mem_wdata), 0);
        reset = 1'b0; tick(2);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        tick(H);
        chk("midrst_wren", wren_cyc - w0, 0);
        chk("midrst_idle", int'(slave_state), 0);
        $display("seq: reset during write data, addr 30");
        v = '{1'b0, 1'b1, MY_ID, 8'h30, 8'h00};
        run_txn(v, 100);

        // Repeated START part-way through a write data byte.
        stop_cond(); start_cond();
        send_byte(MY_ID); send_bit(1'b0); recv_bit(a);
        send_byte(8'h31); recv_bit(a);
        for (int i = 0; i < 5; i++) send_bit(1'b0);
        w0 = wren_cyc;
        start_cond();
        tick(2);
        chk("abort_state", int'(slave_state), 1);
        chk("abort_wren", wren_cyc - w0, 0);
        $display("seq: repeated start during write data, addr 31");
        v = '{1'b0, 1'b1, MY_ID, 8'h31, 8'h00};
        run_txn(v, 101);
        stop_cond();
        tick(4);
        chk("final_idle", int'(slave_state), 0);
        chk("strobes_together", both_cyc, 0);
        chk("strobe_without_ce", noce_cyc, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
